tcm_arb_swc: RTL and testbench

TCM_ARB_SWC -- requirements
Module: tcm_arb_swc

---
 rtl/tcm_arb_swc_if.sv | 41 ++++
 rtl/tcm_arb_swc.sv | 93 +++++++++
 tb/tb_tcm_arb_swc.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_arb_swc_if.sv
// Bus bundle between the IFU/MAU masters, the shared TCM port and the TCM arbiter.
// The slave modport is the arbiter's view; the master modport drives both masters and the TCM response.
interface tcm_arb_swc_if;
  logic [1:0]  ifu_htrans;
  logic [31:0] ifu_haddr;
  logic [2:0]  ifu_hsize;
  logic [1:0]  mau_htrans;
  logic [31:0] mau_haddr;
  logic        mau_hwrite;
  logic [2:0]  mau_hsize;
  logic [31:0] mau_hwdata;
  logic        mau_hmastlock;
  logic        m_hready;
  logic        m_hresp;
  logic [1:0]  m_htrans;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        ifu_hready;
  logic        mau_hready;
  logic        ifu_hresp;
  logic        mau_hresp;
  logic        grant_mau;

  modport slave (
    input  ifu_htrans, ifu_haddr, ifu_hsize,
    input  mau_htrans, mau_haddr, mau_hwrite, mau_hsize, mau_hwdata, mau_hmastlock,
    input  m_hready, m_hresp,
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata,
    output ifu_hready, mau_hready, ifu_hresp, mau_hresp, grant_mau
  );

  modport master (
    output ifu_htrans, ifu_haddr, ifu_hsize,
    output mau_htrans, mau_haddr, mau_hwrite, mau_hsize, mau_hwdata, mau_hmastlock,
    output m_hready, m_hresp,
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata,
    input  ifu_hready, mau_hready, ifu_hresp, mau_hresp, grant_mau
  );
endinterface

// File: rtl/tcm_arb_swc.sv
// Two-master AHB-lite arbiter sharing one TCM port between instruction fetch (IFU) and load/store (MAU).
// MAU has priority, except that IFU gets a slot after four back-to-back MAU grants unless MAU holds a lock.
//
// state  | meaning
// D_NONE | no data phase in flight on the TCM port
// D_IFU  | data phase belongs to the IFU
// D_MAU  | data phase belongs to the MAU (m_hwdata sourced from MAU)
module tcm_arb_swc (
  input  logic          hclk,
  input  logic          hrstn,
  tcm_arb_swc_if.slave  bus
);

  typedef enum logic [1:0] {
    D_NONE = 2'd0,
    D_IFU  = 2'd1,
    D_MAU  = 2'd2
  } dph_t;

  localparam logic [2:0] STARVE_MAX = 3'd4;

  dph_t       d_state;
  logic       agnt;
  logic [2:0] starve_cnt;
  logic       ifu_req;
  logic       mau_req;
  logic       next_agnt;
  logic       grant;

  assign ifu_req = bus.ifu_htrans[1];
  assign mau_req = bus.mau_htrans[1];

  always_comb begin
    next_agnt = agnt;
    if (mau_req && bus.mau_hmastlock)
      next_agnt = 1'b1;
    else if ((starve_cnt == STARVE_MAX) && ifu_req)
      next_agnt = 1'b0;
    else if (mau_req)
      next_agnt = 1'b1;
    else if (ifu_req)
      next_agnt = 1'b0;
  end

  // Reset forces the IFU view onto the bus without waiting for a clock edge.
  assign grant = hrstn & next_agnt;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      agnt       <= 1'b0;
      starve_cnt <= 3'd0;
    end else if (bus.m_hready) begin
      agnt <= grant;
      if (ifu_req && grant)
        starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 3'd1;
      else
        starve_cnt <= 3'd0;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      d_state <= D_NONE;
    end else if (bus.m_hready) begin
      if (grant)
        d_state <= mau_req ? D_MAU : D_NONE;
      else
        d_state <= ifu_req ? D_IFU : D_NONE;
    end
  end

  always_comb begin
    bus.m_htrans = 2'b00;
    if (hrstn) begin
      if (grant && mau_req)
        bus.m_htrans = bus.mau_htrans;
      else if (!grant && ifu_req)
        bus.m_htrans = bus.ifu_htrans;
    end
  end

  assign bus.m_haddr    = grant ? bus.mau_haddr : bus.ifu_haddr;
  assign bus.m_hwrite   = grant & bus.mau_hwrite;
  assign bus.m_hsize    = grant ? bus.mau_hsize : bus.ifu_hsize;
  assign bus.m_hwdata   = (d_state == D_MAU) ? bus.mau_hwdata : 32'h0;
  assign bus.grant_mau  = grant;

  assign bus.ifu_hready = bus.m_hready & ~(ifu_req & grant);
  assign bus.mau_hready = bus.m_hready & ~(mau_req & ~grant);
  assign bus.ifu_hresp  = (d_state == D_IFU) & bus.m_hresp;
  assign bus.mau_hresp  = (d_state == D_MAU) & bus.m_hresp;

endmodule

// File: tb/tb_tcm_arb_swc.sv
// Bench for tcm_arb_swc: directed scenarios plus randomized traffic against a priority-list reference model.
module tb_tcm_arb_swc;
  logic hclk  = 1'b0;
  logic hrstn = 1'b0;
  always #5 hclk = ~hclk;

  tcm_arb_swc_if bus ();
  tcm_arb_swc dut (.hclk(hclk), .hrstn(hrstn), .bus(bus.slave));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns the data phase (0 none, 1 IFU, 2 MAU), last grant, MAU-win streak.
  bit mdl_agnt;
  int mdl_dph;
  int mdl_streak;

  function automatic bit mdl_pick();
    bit ir = bus.ifu_htrans[1];
    bit mr = bus.mau_htrans[1];
    if (mr && bus.mau_hmastlock) return 1'b1;
    if (ir && mdl_streak >= 4)   return 1'b0;
    if (mr)                      return 1'b1;
    if (ir)                      return 1'b0;
    return mdl_agnt;
  endfunction

  task automatic mdl_reset();
    mdl_agnt = 1'b0; mdl_dph = 0; mdl_streak = 0;
  endtask

  task automatic mdl_edge();
    bit g;
    bit ir = bus.ifu_htrans[1];
    bit mr = bus.mau_htrans[1];
    if (!hrstn) begin
      mdl_reset();
    end else if (bus.m_hready) begin
      g = mdl_pick();
      if (g) mdl_dph = mr ? 2 : 0;
      else   mdl_dph = ir ? 1 : 0;
      if (ir && g) mdl_streak = (mdl_streak < 4) ? mdl_streak + 1 : 4;
      else         mdl_streak = 0;
      mdl_agnt = g;
    end
  endtask

  function automatic logic [74:0] mdl_outputs();
    bit g, ir, mr, sreq;
    logic [1:0] tr;
    ir = bus.ifu_htrans[1];
    mr = bus.mau_htrans[1];
    g  = hrstn ? mdl_pick() : 1'b0;
    sreq = g ? mr : ir;
    tr = (hrstn && sreq) ? (g ? bus.mau_htrans : bus.ifu_htrans) : 2'b00;
    return {g, tr, g ? bus.mau_haddr : bus.ifu_haddr, g & bus.mau_hwrite,
            g ? bus.mau_hsize : bus.ifu_hsize,
            (mdl_dph == 2) ? bus.mau_hwdata : 32'h0,
            bus.m_hready & ~(ir & g), bus.m_hready & ~(mr & ~g),
            (mdl_dph == 1) & bus.m_hresp, (mdl_dph == 2) & bus.m_hresp};
  endfunction

  task automatic tick();
    @(posedge hclk);
    mdl_edge();
    #1;
  endtask

  task automatic set_idle();
    bus.ifu_htrans = 2'b00; bus.ifu_haddr = 32'h0; bus.ifu_hsize = 3'd2;
    bus.mau_htrans = 2'b00; bus.mau_haddr = 32'h0; bus.mau_hwrite = 1'b0;
    bus.mau_hsize = 3'd2; bus.mau_hwdata = 32'h0; bus.mau_hmastlock = 1'b0;
    bus.m_hready = 1'b1; bus.m_hresp = 1'b0;
  endtask

  task automatic test_reset();
    hrstn = 1'b0;
    set_idle();
    bus.ifu_htrans = 2'b10; bus.mau_htrans = 2'b10; bus.mau_hmastlock = 1'b1;
    bus.mau_hwdata = 32'hA5A5_5A5A; bus.m_hresp = 1'b1;
    tick(); tick(); #3;
    n_chk++; if (bus.grant_mau !== 1'b0) $display("FAIL rst_grant got %0b exp 0", bus.grant_mau); else n_pass++;
    n_chk++; if (bus.m_htrans !== 2'b00) $display("FAIL rst_htrans got %0h exp 0", bus.m_htrans); else n_pass++;
    n_chk++; if (bus.m_hwdata !== 32'h0) $display("FAIL rst_hwdata got %h exp 0", bus.m_hwdata); else n_pass++;
    n_chk++; if ({bus.ifu_hresp, bus.mau_hresp} !== 2'b00)
      $display("FAIL rst_hresp got %b exp 00", {bus.ifu_hresp, bus.mau_hresp}); else n_pass++;
    set_idle();
    hrstn = 1'b1;
    tick();
  endtask

  task automatic test_ifu_only();
    set_idle();
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h100;
    #3;
    n_chk++; if (bus.m_haddr !== 32'h100) $display("FAIL ifu_addr got %h exp 100", bus.m_haddr); else n_pass++;
    n_chk++; if (bus.grant_mau !== 1'b0) $display("FAIL ifu_grant got %0b exp 0", bus.grant_mau); else n_pass++;
    n_chk++; if (bus.ifu_hready !== 1'b1) $display("FAIL ifu_ready got %0b exp 1", bus.ifu_hready); else n_pass++;
    n_chk++; if (bus.m_htrans !== 2'b10) $display("FAIL ifu_htrans got %0h exp 2", bus.m_htrans); else n_pass++;
    tick();
    set_idle();
    bus.m_hready = 1'b0; bus.m_hresp = 1'b1;
    #3;
    n_chk++; if ({bus.ifu_hresp, bus.mau_hresp} !== 2'b10)
      $display("FAIL ifu_dphase_resp got %b exp 10", {bus.ifu_hresp, bus.mau_hresp}); else n_pass++;
    tick();
    bus.m_hready = 1'b1;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_contention();
    set_idle();
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h104;
    bus.mau_htrans = 2'b10; bus.mau_haddr = 32'h2000; bus.mau_hwrite = 1'b1;
    #3;
    n_chk++; if (bus.m_haddr !== 32'h2000) $display("FAIL cont_c1_addr got %h exp 2000", bus.m_haddr); else n_pass++;
    n_chk++; if (bus.ifu_hready !== 1'b0) $display("FAIL cont_c1_ifu_ready got %0b exp 0", bus.ifu_hready); else n_pass++;
    n_chk++; if (bus.m_hwrite !== 1'b1) $display("FAIL cont_c1_hwrite got %0b exp 1", bus.m_hwrite); else n_pass++;
    n_chk++; if (bus.m_hwdata !== 32'h0) $display("FAIL cont_c1_hwdata got %h exp 0", bus.m_hwdata); else n_pass++;
    tick();
    bus.mau_htrans = 2'b00; bus.mau_hwrite = 1'b0; bus.mau_hwdata = 32'hDEAD_BEEF;
    #3;
    n_chk++; if (bus.m_hwdata !== 32'hDEAD_BEEF) $display("FAIL cont_c2_hwdata got %h exp deadbeef", bus.m_hwdata); else n_pass++;
    n_chk++; if (bus.m_haddr !== 32'h104) $display("FAIL cont_c2_addr got %h exp 104", bus.m_haddr); else n_pass++;
    n_chk++; if (bus.ifu_hready !== 1'b1) $display("FAIL cont_c2_ifu_ready got %0b exp 1", bus.ifu_hready); else n_pass++;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_starvation();
    set_idle();
    tick();
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h400;
    bus.mau_htrans = 2'b10; bus.mau_haddr = 32'h5000;
    for (int i = 0; i < 15; i++) begin
      #3;
      n_chk++;
      if (bus.grant_mau !== ((i % 5) != 4))
        $display("FAIL starve_slot%0d got %0b exp %0b", i, bus.grant_mau, ((i % 5) != 4));
      else n_pass++;
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_lock();
    set_idle();
    tick();
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h600;
    bus.mau_htrans = 2'b10; bus.mau_haddr = 32'h7000; bus.mau_hmastlock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      n_chk++; if (bus.grant_mau !== 1'b1) $display("FAIL lock_xfer%0d got %0b exp 1", i, bus.grant_mau); else n_pass++;
      tick();
    end
    bus.mau_hmastlock = 1'b0;
    #3;
    n_chk++; if (bus.grant_mau !== 1'b0) $display("FAIL lock_release got %0b exp 0", bus.grant_mau); else n_pass++;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_wait_state();
    set_idle();
    tick();
    bus.mau_htrans = 2'b10; bus.mau_haddr = 32'h3000; bus.mau_hwrite = 1'b1;
    tick();
    bus.mau_haddr = 32'h3004; bus.mau_hwdata = 32'h1234_5678;
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h200;
    bus.m_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_chk++; if (bus.grant_mau !== 1'b1) $display("FAIL wait%0d_grant got %0b exp 1", i, bus.grant_mau); else n_pass++;
      n_chk++; if (bus.m_haddr !== 32'h3004) $display("FAIL wait%0d_addr got %h exp 3004", i, bus.m_haddr); else n_pass++;
      n_chk++; if ({bus.ifu_hready, bus.mau_hready} !== 2'b00)
        $display("FAIL wait%0d_ready got %b exp 00", i, {bus.ifu_hready, bus.mau_hready}); else n_pass++;
      n_chk++; if (bus.m_hwdata !== 32'h1234_5678) $display("FAIL wait%0d_hwdata got %h exp 12345678", i, bus.m_hwdata); else n_pass++;
      tick();
    end
    bus.m_hready = 1'b1;
    #3;
    n_chk++; if (bus.mau_hready !== 1'b1) $display("FAIL wait_resume got %0b exp 1", bus.mau_hready); else n_pass++;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.mau_htrans = 2'b10; bus.mau_haddr = 32'h4000; bus.mau_hwrite = 1'b1;
    tick();
    bus.mau_hwdata = 32'hCAFE_F00D; bus.m_hready = 1'b0; bus.m_hresp = 1'b1;
    #2;
    hrstn = 1'b0;
    mdl_reset();
    #1;
    n_chk++; if (bus.m_hwdata !== 32'h0) $display("FAIL rmid_hwdata got %h exp 0", bus.m_hwdata); else n_pass++;
    n_chk++; if (bus.grant_mau !== 1'b0) $display("FAIL rmid_grant got %0b exp 0", bus.grant_mau); else n_pass++;
    n_chk++; if (bus.m_htrans !== 2'b00) $display("FAIL rmid_htrans got %0h exp 0", bus.m_htrans); else n_pass++;
    n_chk++; if (bus.mau_hresp !== 1'b0) $display("FAIL rmid_mau_hresp got %0b exp 0", bus.mau_hresp); else n_pass++;
    tick();
    set_idle();
    bus.ifu_htrans = 2'b10; bus.ifu_haddr = 32'h300;
    #2;
    hrstn = 1'b1;
    #1;
    n_chk++; if (bus.grant_mau !== 1'b0) $display("FAIL rmid_first_grant got %0b exp 0", bus.grant_mau); else n_pass++;
    tick();
    set_idle();
    bus.m_hready = 1'b0; bus.m_hresp = 1'b1;
    #3;
    n_chk++; if (bus.ifu_hresp !== 1'b1) $display("FAIL rmid_ifu_dphase got %0b exp 1", bus.ifu_hresp); else n_pass++;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_random();
    logic [74:0] exp_v, got_v;
    for (int i = 0; i < 400; i++) begin
      bus.ifu_htrans    = 2'($urandom_range(0, 3));
      bus.ifu_haddr     = $urandom;
      bus.ifu_hsize     = 3'($urandom_range(0, 2));
      bus.mau_htrans    = 2'($urandom_range(0, 3));
      bus.mau_haddr     = $urandom;
      bus.mau_hwrite    = 1'($urandom_range(0, 1));
      bus.mau_hsize     = 3'($urandom_range(0, 2));
      bus.mau_hwdata    = $urandom;
      bus.mau_hmastlock = ($urandom_range(0, 3) == 0);
      bus.m_hready      = ($urandom_range(0, 4) != 0);
      bus.m_hresp       = ($urandom_range(0, 9) == 0);
      #3;
      exp_v = mdl_outputs();
      got_v = {bus.grant_mau, bus.m_htrans, bus.m_haddr, bus.m_hwrite, bus.m_hsize, bus.m_hwdata,
               bus.ifu_hready, bus.mau_hready, bus.ifu_hresp, bus.mau_hresp};
      n_chk++;
      if (got_v !== exp_v) $display("FAIL rand_cycle%0d got %h exp %h", i, got_v, exp_v);
      else n_pass++;
      tick();
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    mdl_reset();
    test_reset();
    test_ifu_only();
    test_contention();
    test_starvation();
    test_lock();
    test_wait_state();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
